mem_wb_skid_stage: RTL and testbench

MEM_WB_SKID_STAGE -- requirements
Module: mem_wb_skid_stage

---
 rtl/mem_wb_skid_stage.sv | 126 ++++++++++++
 tb/tb_mem_wb_skid_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_stage.sv
// ============================================================================
// mem_wb_skid_stage : MEM->WB pipeline register with one-entry skid buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_wb_skid_stage #(
  parameter int XLEN  = 64,
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_result,
  input  logic [XLEN-1:0]  in_rdata,
  input  logic [RA_W-1:0]  in_rd,
  input  logic             in_memtoreg,
  input  logic             in_regwrite,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  wb_data,
  output logic [RA_W-1:0]  wb_rd,
  output logic             wb_we,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] retire_cnt
);

  // Main entry (drives outputs)
  logic            m_valid;
  logic [XLEN-1:0] m_result;
  logic [XLEN-1:0] m_rdata;
  logic [RA_W-1:0] m_rd;
  logic            m_memtoreg;
  logic            m_regwrite;

  // Skid entry
  logic            s_valid;
  logic [XLEN-1:0] s_result;
  logic [XLEN-1:0] s_rdata;
  logic [RA_W-1:0] s_rd;
  logic            s_memtoreg;
  logic            s_regwrite;

  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             pop;

  // in_ready comes straight from the skid flop so upstream sees no comb path
  assign in_ready   = !s_valid;
  assign out_valid  = m_valid;
  assign accept     = in_valid && in_ready;
  assign pop        = m_valid && out_ready;
  assign occupancy  = {1'b0, m_valid} + {1'b0, s_valid};
  assign wb_data    = m_memtoreg ? m_rdata : m_result;
  assign wb_rd      = m_rd;
  assign wb_we      = pop && m_regwrite && (m_rd != '0);
  assign retire_cnt = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid    <= 1'b0;
      m_result   <= '0;
      m_rdata    <= '0;
      m_rd       <= '0;
      m_memtoreg <= 1'b0;
      m_regwrite <= 1'b0;
      s_valid    <= 1'b0;
      s_result   <= '0;
      s_rdata    <= '0;
      s_rd       <= '0;
      s_memtoreg <= 1'b0;
      s_regwrite <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (pop) begin
      if (s_valid) begin
        m_result   <= s_result;
        m_rdata    <= s_rdata;
        m_rd       <= s_rd;
        m_memtoreg <= s_memtoreg;
        m_regwrite <= s_regwrite;
        s_valid    <= 1'b0;
      end else if (accept) begin
        m_result   <= in_result;
        m_rdata    <= in_rdata;
        m_rd       <= in_rd;
        m_memtoreg <= in_memtoreg;
        m_regwrite <= in_regwrite;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!m_valid) begin
        m_valid    <= 1'b1;
        m_result   <= in_result;
        m_rdata    <= in_rdata;
        m_rd       <= in_rd;
        m_memtoreg <= in_memtoreg;
        m_regwrite <= in_regwrite;
      end else begin
        s_valid    <= 1'b1;
        s_result   <= in_result;
        s_rdata    <= in_rdata;
        s_rd       <= in_rd;
        s_memtoreg <= in_memtoreg;
        s_regwrite <= in_regwrite;
      end
    end
  end

  // A writeback in the flush cycle still commits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (wb_we) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_skid_stage.sv
// Table-driven bench for mem_wb_skid_stage plus hand sequences for
// asynchronous reset and retire-counter wrap.
`default_nettype none

module tb_mem_wb_skid_stage;

  localparam int XLEN  = 64;
  localparam int RA_W  = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [XLEN-1:0]  in_result = '0;
  logic [XLEN-1:0]  in_rdata = '0;
  logic [RA_W-1:0]  in_rd = '0;
  logic             in_memtoreg = 1'b0;
  logic             in_regwrite = 1'b0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  wb_data;
  logic [RA_W-1:0]  wb_rd;
  logic             wb_we;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] retire_cnt;

  mem_wb_skid_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_rdata(in_rdata), .in_rd(in_rd),
    .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
    .occupancy(occupancy), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [63:0] res;
    logic [63:0] rdat;
    logic [4:0]  rd;
    logic        mtr;
    logic        rw;
    logic        ordy;
    logic        fl;
    logic        dchk;
    logic        ov;
    logic        ir;
    logic [1:0]  occ;
    logic [63:0] wbd;
    logic [4:0]  wbrd;
    logic        we;
    logic [3:0]  cnt;
  } vec_t;

  function automatic vec_t mk(
    input logic iv, input logic [63:0] res, input logic [63:0] rdat,
    input logic [4:0] rd, input logic mtr, input logic rw,
    input logic ordy, input logic fl, input logic dchk,
    input logic ov, input logic ir, input logic [1:0] occ,
    input logic [63:0] wbd, input logic [4:0] wbrd,
    input logic we, input logic [3:0] cnt);
    vec_t v;
    v.iv = iv; v.res = res; v.rdat = rdat; v.rd = rd; v.mtr = mtr;
    v.rw = rw; v.ordy = ordy; v.fl = fl; v.dchk = dchk; v.ov = ov;
    v.ir = ir; v.occ = occ; v.wbd = wbd; v.wbrd = wbrd; v.we = we;
    v.cnt = cnt;
    return v;
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  vec_t tv[22];

  initial begin
    //            iv res    rdat   rd mtr rw ordy fl dchk | ov ir occ wbd   wbrd we cnt
    tv[0]  = mk(1, 64'h11, 64'h0,  3, 0, 1, 1, 0, 1,  0, 1, 0, 64'h0,  0, 0, 0);
    tv[1]  = mk(0, 64'h0,  64'h0,  0, 0, 0, 1, 0, 1,  1, 1, 1, 64'h11, 3, 1, 0);
    tv[2]  = mk(0, 64'h0,  64'h0,  0, 0, 0, 1, 0, 0,  0, 1, 0, 64'h0,  0, 0, 1);
    tv[3]  = mk(1, 64'hA1, 64'h0,  4, 0, 1, 0, 0, 0,  0, 1, 0, 64'h0,  0, 0, 1);
    tv[4]  = mk(1, 64'hB2, 64'h0,  5, 0, 1, 0, 0, 1,  1, 1, 1, 64'hA1, 4, 0, 1);
    tv[5]  = mk(1, 64'hC3, 64'h0,  6, 0, 1, 0, 0, 1,  1, 0, 2, 64'hA1, 4, 0, 1);
    tv[6]  = mk(0, 64'h0,  64'h0,  0, 0, 0, 1, 0, 1,  1, 0, 2, 64'hA1, 4, 1, 1);
    tv[7]  = mk(0, 64'h0,  64'h0,  0, 0, 0, 1, 0, 1,  1, 1, 1, 64'hB2, 5, 1, 2);
    tv[8]  = mk(1, 64'hBEEF, 64'hDEAD, 0, 1, 1, 0, 0, 0, 0, 1, 0, 64'h0, 0, 0, 3);
    tv[9]  = mk(0, 64'h0,  64'h0,  0, 0, 0, 1, 0, 1,  1, 1, 1, 64'hDEAD, 0, 0, 3);
    tv[10] = mk(0, 64'h0,  64'h0,  0, 0, 0, 0, 0, 0,  0, 1, 0, 64'h0,  0, 0, 3);
    tv[11] = mk(1, 64'h21, 64'h0,  7, 0, 1, 0, 0, 0,  0, 1, 0, 64'h0,  0, 0, 3);
    tv[12] = mk(1, 64'h22, 64'h0,  8, 0, 1, 0, 0, 1,  1, 1, 1, 64'h21, 7, 0, 3);
    tv[13] = mk(1, 64'h23, 64'h0,  9, 0, 1, 0, 1, 1,  1, 0, 2, 64'h21, 7, 0, 3);
    tv[14] = mk(1, 64'h24, 64'h0, 10, 0, 1, 0, 0, 0,  0, 1, 0, 64'h0,  0, 0, 3);
    tv[15] = mk(1, 64'h25, 64'h0, 11, 0, 1, 1, 1, 1,  1, 1, 1, 64'h24, 10, 1, 3);
    tv[16] = mk(0, 64'h0,  64'h0,  0, 0, 0, 1, 0, 0,  0, 1, 0, 64'h0,  0, 0, 4);
    tv[17] = mk(1, 64'h31, 64'h99, 1, 1, 1, 1, 0, 0,  0, 1, 0, 64'h0,  0, 0, 4);
    tv[18] = mk(1, 64'h32, 64'h0,  2, 0, 1, 1, 0, 1,  1, 1, 1, 64'h99, 1, 1, 4);
    tv[19] = mk(1, 64'h33, 64'h0,  3, 0, 0, 1, 0, 1,  1, 1, 1, 64'h32, 2, 1, 5);
    tv[20] = mk(0, 64'h0,  64'h0,  0, 0, 0, 1, 0, 1,  1, 1, 1, 64'h33, 3, 0, 6);
    tv[21] = mk(0, 64'h0,  64'h0,  0, 0, 0, 0, 0, 0,  0, 1, 0, 64'h0,  0, 0, 6);

    // Release reset between edges; first vector is applied before the next edge
    #12 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 22; i++) begin
      in_valid    = tv[i].iv;
      in_result   = tv[i].res;
      in_rdata    = tv[i].rdat;
      in_rd       = tv[i].rd;
      in_memtoreg = tv[i].mtr;
      in_regwrite = tv[i].rw;
      out_ready   = tv[i].ordy;
      flush       = tv[i].fl;
      @(negedge clk);
      check($sformatf("v%0d out_valid", i), {63'b0, out_valid}, {63'b0, tv[i].ov});
      check($sformatf("v%0d in_ready", i), {63'b0, in_ready}, {63'b0, tv[i].ir});
      check($sformatf("v%0d occupancy", i), {62'b0, occupancy}, {62'b0, tv[i].occ});
      check($sformatf("v%0d wb_we", i), {63'b0, wb_we}, {63'b0, tv[i].we});
      check($sformatf("v%0d retire_cnt", i), {60'b0, retire_cnt}, {60'b0, tv[i].cnt});
      if (tv[i].dchk) begin
        check($sformatf("v%0d wb_data", i), wb_data, tv[i].wbd);
        check($sformatf("v%0d wb_rd", i), {59'b0, wb_rd}, {59'b0, tv[i].wbrd});
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;

    // Asynchronous reset mid-cycle with one entry held
    in_valid = 1'b1; in_result = 64'h55; in_rdata = '0; in_rd = 5'd2;
    in_memtoreg = 1'b0; in_regwrite = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    check("rst pre occupancy", {62'b0, occupancy}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rst out_valid", {63'b0, out_valid}, 64'd0);
    check("rst in_ready", {63'b0, in_ready}, 64'd1);
    check("rst occupancy", {62'b0, occupancy}, 64'd0);
    check("rst wb_data", wb_data, 64'd0);
    check("rst wb_rd", {59'b0, wb_rd}, 64'd0);
    check("rst wb_we", {63'b0, wb_we}, 64'd0);
    check("rst retire_cnt", {60'b0, retire_cnt}, 64'd0);
    #1 reset = 1'b0;
    // First accept on the first edge after release
    in_valid = 1'b1; in_result = 64'h66; in_rd = 5'd0; out_ready = 1'b0;
    @(posedge clk); #1;
    check("post-rst out_valid", {63'b0, out_valid}, 64'd1);
    check("post-rst wb_data", wb_data, 64'h66);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("post-rst drain occupancy", {62'b0, occupancy}, 64'd0);
    check("post-rst retire_cnt", {60'b0, retire_cnt}, 64'd0);

    // 17 committed writes wrap a 4-bit counter to 1
    in_valid = 1'b1; in_rd = 5'd1; in_regwrite = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      in_result = 64'(k + 256);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("wrap retire_cnt", {60'b0, retire_cnt}, 64'd1);
    check("wrap out_valid", {63'b0, out_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
